// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the ID/EX pipeline boundary into a single interface.
//   ID-side inputs : id_valid, id_rs/rt/rd, id_rs_data, id_rt_data, id_imm,
//                    id_shamt, id_a_sel, id_b_sel, id_alu_op, control bits
//   Hazard input   : flush (branch taken, kill the instruction entering EX)
//   Forward inputs : exmem_* and memwb_* writeback descriptors
//   EX-side outputs: stall_id, alu_a/alu_b/alu_op, ex_* latched fields,
//                    ex_store_data, stall_count
// The master modport is the pipeline around the stage. The slave modport is
// the stage itself.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int B_DAT = 32,
   parameter int B_OP  = 6,
   parameter int B_REG = 5,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [B_REG-1:0] id_rs;
   logic [B_REG-1:0] id_rt;
   logic [B_REG-1:0] id_rd;
   logic [B_DAT-1:0] id_rs_data;
   logic [B_DAT-1:0] id_rt_data;
   logic [B_DAT-1:0] id_imm;
   logic [4:0]       id_shamt;
   logic             id_a_sel;
   logic [1:0]       id_b_sel;
   logic [B_OP-1:0]  id_alu_op;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             id_mem_write;
   logic             flush;

   logic             exmem_reg_write;
   logic [B_REG-1:0] exmem_rd;
   logic [B_DAT-1:0] exmem_result;
   logic             memwb_reg_write;
   logic [B_REG-1:0] memwb_rd;
   logic [B_DAT-1:0] memwb_result;

   logic             stall_id;
   logic [B_DAT-1:0] alu_a;
   logic [B_DAT-1:0] alu_b;
   logic [B_OP-1:0]  alu_op;
   logic             ex_valid;
   logic [B_REG-1:0] ex_rd;
   logic             ex_reg_write;
   logic             ex_mem_read;
   logic             ex_mem_write;
   logic [B_DAT-1:0] ex_store_data;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             id_shamt, id_a_sel, id_b_sel, id_alu_op, id_reg_write,
             id_mem_read, id_mem_write, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      input  stall_id, alu_a, alu_b, alu_op, ex_valid, ex_rd, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_store_data, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             id_shamt, id_a_sel, id_b_sel, id_alu_op, id_reg_write,
             id_mem_read, id_mem_write, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      output stall_id, alu_a, alu_b, alu_op, ex_valid, ex_rd, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_store_data, stall_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection.
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : id_ex_stage_if.slave carrying the ID fields, flush, the EX/MEM
//           and MEM/WB forward sources, and all EX-side outputs
// Operands reach the ALU one cycle after ID; forwarding is combinational on
// the latched source indices and adds no latency. A load in EX whose
// destination is read by the instruction in ID raises stall_id and the next
// edge inserts a bubble.
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int              B_DAT   = 32,
   parameter int              B_OP    = 6,
   parameter int              B_REG   = 5,
   parameter int              CNT_W   = 16,
   parameter logic [B_OP-1:0] ALU_ADD = 'h20
) (
   input logic           clk,
   input logic           rst_n,
   id_ex_stage_if.slave  bus
);

   typedef struct packed {
      logic [B_REG-1:0] rs;
      logic [B_REG-1:0] rt;
      logic [B_REG-1:0] rd;
      logic [B_DAT-1:0] rs_data;
      logic [B_DAT-1:0] rt_data;
      logic [B_DAT-1:0] imm;
      logic [4:0]       shamt;
      logic             a_sel;
      logic [1:0]       b_sel;
      logic [B_OP-1:0]  alu_op;
   } fields_t;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } ctl_t;

   fields_t          fields_q, fields_d;
   ctl_t             ctl_q, ctl_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             stall;
   logic [B_DAT-1:0] fwd_rs, fwd_rt;

   // EX/MEM has priority over MEM/WB because it holds the younger result.
   // Register 0 is hard-wired, so a write naming it must never be forwarded.
   function automatic logic [B_DAT-1:0] forward(
      input logic [B_REG-1:0] idx,
      input logic [B_DAT-1:0] latched,
      input logic             em_we,
      input logic [B_REG-1:0] em_rd,
      input logic [B_DAT-1:0] em_res,
      input logic             mw_we,
      input logic [B_REG-1:0] mw_rd,
      input logic [B_DAT-1:0] mw_res
   );
      if (em_we && (em_rd != '0) && (em_rd == idx)) begin
         return em_res;
      end else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) begin
         return mw_res;
      end
      return latched;
   endfunction

   // The loaded value only exists after MEM, so a consumer in ID must wait
   // one cycle; a load to register 0 produces nothing worth waiting for.
   always_comb begin
      stall = bus.id_valid && ctl_q.valid && ctl_q.mem_read &&
              (fields_q.rd != '0) &&
              ((fields_q.rd == bus.id_rs) || (fields_q.rd == bus.id_rt));
   end

   // Flush and stall both insert the same bubble: only the control bits are
   // cleared, data fields hold since nothing downstream will use them.
   // A stall hidden by a flush is not counted because it costs no extra cycle.
   always_comb begin
      fields_d      = fields_q;
      ctl_d         = ctl_q;
      stall_count_d = stall_count_q;
      if (bus.flush || stall) begin
         ctl_d = '0;
      end else begin
         fields_d.rs      = bus.id_rs;
         fields_d.rt      = bus.id_rt;
         fields_d.rd      = bus.id_rd;
         fields_d.rs_data = bus.id_rs_data;
         fields_d.rt_data = bus.id_rt_data;
         fields_d.imm     = bus.id_imm;
         fields_d.shamt   = bus.id_shamt;
         fields_d.a_sel   = bus.id_a_sel;
         fields_d.b_sel   = bus.id_b_sel;
         fields_d.alu_op  = bus.id_alu_op;
         ctl_d.valid      = bus.id_valid;
         ctl_d.reg_write  = bus.id_reg_write;
         ctl_d.mem_read   = bus.id_mem_read;
         ctl_d.mem_write  = bus.id_mem_write;
      end
      if (stall && !bus.flush && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   // Pipeline register; reset leaves a harmless ADD bubble in EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fields_q        <= '0;
         fields_q.alu_op <= ALU_ADD;
         ctl_q           <= '0;
         stall_count_q   <= '0;
      end else begin
         fields_q        <= fields_d;
         ctl_q           <= ctl_d;
         stall_count_q   <= stall_count_d;
      end
   end

   // Operand forwarding and selection.
   always_comb begin
      fwd_rs = forward(fields_q.rs, fields_q.rs_data,
                       bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                       bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
      fwd_rt = forward(fields_q.rt, fields_q.rt_data,
                       bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                       bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
      bus.alu_a = fields_q.a_sel ? fwd_rt : fwd_rs;
      unique case (fields_q.b_sel)
         2'd0:    bus.alu_b = fwd_rt;
         2'd1:    bus.alu_b = fields_q.imm;
         2'd2:    bus.alu_b = {{(B_DAT-5){1'b0}}, fields_q.shamt};
         default: bus.alu_b = '0;
      endcase
      bus.ex_store_data = fwd_rt;
   end

   assign bus.stall_id     = stall;
   assign bus.alu_op       = fields_q.alu_op;
   assign bus.ex_valid     = ctl_q.valid;
   assign bus.ex_rd        = fields_q.rd;
   assign bus.ex_reg_write = ctl_q.reg_write;
   assign bus.ex_mem_read  = ctl_q.mem_read;
   assign bus.ex_mem_write = ctl_q.mem_write;
   assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: a table of single-cycle vectors for
// forwarding/operand selection, hand-written sequences for load-use, flush
// plus stall and mid-stream reset, and a narrow-counter instance for the
// saturation behaviour.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam logic [5:0] OP_ADD = 6'h20;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   id_ex_stage_if #(.B_DAT(32), .B_OP(6), .B_REG(5), .CNT_W(16)) bus ();
   id_ex_stage_if #(.B_DAT(32), .B_OP(6), .B_REG(5), .CNT_W(4))  sbus ();

   id_ex_stage #(.B_DAT(32), .B_OP(6), .B_REG(5), .CNT_W(16), .ALU_ADD(OP_ADD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   id_ex_stage #(.B_DAT(32), .B_OP(6), .B_REG(5), .CNT_W(4), .ALU_ADD(OP_ADD)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sbus.slave)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        valid;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  shamt;
      logic        a_sel;
      logic [1:0]  b_sel;
      logic [5:0]  op;
      logic        rw, mr, mw, flush;
      logic        em_we;
      logic [4:0]  em_rd;
      logic [31:0] em_res;
      logic        mw_we;
      logic [4:0]  mw_rd;
      logic [31:0] mw_res;
      logic        chk_data;
      logic        exp_valid, exp_rw, exp_mw;
      logic [31:0] exp_a, exp_b, exp_store;
      logic [5:0]  exp_op;
      logic [4:0]  exp_rd;
   } vec_t;

   vec_t tbl[$];

   // Drive one vector onto the main interface.
   task automatic applyStimulus(input vec_t v);
      bus.id_valid        = v.valid;
      bus.id_rs           = v.rs;
      bus.id_rt           = v.rt;
      bus.id_rd           = v.rd;
      bus.id_rs_data      = v.rs_data;
      bus.id_rt_data      = v.rt_data;
      bus.id_imm          = v.imm;
      bus.id_shamt        = v.shamt;
      bus.id_a_sel        = v.a_sel;
      bus.id_b_sel        = v.b_sel;
      bus.id_alu_op       = v.op;
      bus.id_reg_write    = v.rw;
      bus.id_mem_read     = v.mr;
      bus.id_mem_write    = v.mw;
      bus.flush           = v.flush;
      bus.exmem_reg_write = v.em_we;
      bus.exmem_rd        = v.em_rd;
      bus.exmem_result    = v.em_res;
      bus.memwb_reg_write = v.mw_we;
      bus.memwb_rd        = v.mw_rd;
      bus.memwb_result    = v.mw_res;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t blank();
      vec_t v;
      v = '{default: '0};
      v.op     = OP_ADD;
      v.exp_op = OP_ADD;
      return v;
   endfunction

   initial begin
      vec_t v;
      vec_t idle;
      compared   = 0;
      mismatched = 0;
      idle       = blank();

      // ---------------- vector table ----------------
      // plain add, no forwarding
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 2; v.rd = 3; v.rs_data = 10; v.rt_data = 20; v.rw = 1;
      v.chk_data = 1; v.exp_valid = 1; v.exp_rw = 1; v.exp_a = 10; v.exp_b = 20; v.exp_store = 20; v.exp_rd = 3;
      tbl.push_back(v);
      // $3 in both stages: EX/MEM wins
      v = blank(); v.valid = 1; v.rs = 3; v.rt = 2; v.rd = 6; v.rs_data = 100; v.rt_data = 20;
      v.em_we = 1; v.em_rd = 3; v.em_res = 5; v.mw_we = 1; v.mw_rd = 3; v.mw_res = 9;
      v.chk_data = 1; v.exp_valid = 1; v.exp_a = 5; v.exp_b = 20; v.exp_store = 20; v.exp_rd = 6;
      tbl.push_back(v);
      // same, but EX/MEM names $0 so MEM/WB supplies
      v.em_rd = 0; v.exp_a = 9;
      tbl.push_back(v);
      // shamt operand
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 2; v.rd = 7; v.rs_data = 10; v.rt_data = 20; v.shamt = 7; v.b_sel = 2; v.op = 6'h00;
      v.chk_data = 1; v.exp_valid = 1; v.exp_a = 10; v.exp_b = 32'd7; v.exp_store = 20; v.exp_rd = 7; v.exp_op = 6'h00;
      tbl.push_back(v);
      // sign-extended immediate
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 2; v.rd = 8; v.rs_data = 10; v.rt_data = 20; v.imm = 32'hFFFF_FFF0; v.b_sel = 1;
      v.chk_data = 1; v.exp_valid = 1; v.exp_a = 10; v.exp_b = 32'hFFFF_FFF0; v.exp_store = 20; v.exp_rd = 8;
      tbl.push_back(v);
      // a from rt, b forced to zero
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 2; v.rd = 9; v.rs_data = 10; v.rt_data = 20; v.a_sel = 1; v.b_sel = 3;
      v.chk_data = 1; v.exp_valid = 1; v.exp_a = 20; v.exp_b = 0; v.exp_store = 20; v.exp_rd = 9;
      tbl.push_back(v);
      // $0 never forwards; rt forwarded from MEM/WB into b and store data
      v = blank(); v.valid = 1; v.rs = 0; v.rt = 2; v.rd = 10; v.rs_data = 32'h55; v.rt_data = 20;
      v.em_we = 1; v.em_rd = 0; v.em_res = 32'hAA; v.mw_we = 1; v.mw_rd = 2; v.mw_res = 32'h77;
      v.chk_data = 1; v.exp_valid = 1; v.exp_a = 32'h55; v.exp_b = 32'h77; v.exp_store = 32'h77; v.exp_rd = 10;
      tbl.push_back(v);
      // EX/MEM match without write enable is ignored; store control latched
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 2; v.rd = 11; v.rs_data = 10; v.rt_data = 20; v.mw = 1;
      v.em_we = 0; v.em_rd = 1; v.em_res = 1; v.mw_we = 1; v.mw_rd = 1; v.mw_res = 32'h33;
      v.chk_data = 1; v.exp_valid = 1; v.exp_mw = 1; v.exp_a = 32'h33; v.exp_b = 20; v.exp_store = 20; v.exp_rd = 11;
      tbl.push_back(v);
      // flush kills the incoming instruction
      v = blank(); v.valid = 1; v.rs = 5; v.rt = 6; v.rd = 12; v.rw = 1; v.mw = 1; v.flush = 1;
      v.chk_data = 0; v.exp_valid = 0; v.exp_rw = 0; v.exp_mw = 0;
      tbl.push_back(v);
      // invalid instruction: fields latched, ex_valid low
      v = blank(); v.valid = 0; v.rs = 1; v.rt = 2; v.rd = 13; v.rs_data = 32'h44; v.rt_data = 32'h66; v.imm = 32'h12; v.b_sel = 1; v.op = 6'h22;
      v.chk_data = 1; v.exp_valid = 0; v.exp_a = 32'h44; v.exp_b = 32'h12; v.exp_store = 32'h66; v.exp_rd = 13; v.exp_op = 6'h22;
      tbl.push_back(v);

      // ---------------- reset ----------------
      rst_n = 1'b0;
      applyStimulus(idle);
      sbus.id_valid = 0; sbus.id_rs = 0; sbus.id_rt = 0; sbus.id_rd = 0;
      sbus.id_rs_data = 0; sbus.id_rt_data = 0; sbus.id_imm = 0; sbus.id_shamt = 0;
      sbus.id_a_sel = 0; sbus.id_b_sel = 0; sbus.id_alu_op = OP_ADD;
      sbus.id_reg_write = 0; sbus.id_mem_read = 0; sbus.id_mem_write = 0; sbus.flush = 0;
      sbus.exmem_reg_write = 0; sbus.exmem_rd = 0; sbus.exmem_result = 0;
      sbus.memwb_reg_write = 0; sbus.memwb_rd = 0; sbus.memwb_result = 0;
      #12;
      checkOutput("reset ex_valid", bus.ex_valid, 0);
      checkOutput("reset alu_op", bus.alu_op, OP_ADD);
      checkOutput("reset stall_count", bus.stall_count, 0);
      checkOutput("reset alu_a", bus.alu_a, 0);
      checkOutput("reset ex_reg_write", bus.ex_reg_write, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // ---------------- table ----------------
      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         step();
         checkOutput($sformatf("vec%0d ex_valid", i), bus.ex_valid, tbl[i].exp_valid);
         checkOutput($sformatf("vec%0d ex_reg_write", i), bus.ex_reg_write, tbl[i].exp_rw);
         checkOutput($sformatf("vec%0d ex_mem_write", i), bus.ex_mem_write, tbl[i].exp_mw);
         if (tbl[i].chk_data) begin
            checkOutput($sformatf("vec%0d alu_a", i), bus.alu_a, tbl[i].exp_a);
            checkOutput($sformatf("vec%0d alu_b", i), bus.alu_b, tbl[i].exp_b);
            checkOutput($sformatf("vec%0d alu_op", i), bus.alu_op, tbl[i].exp_op);
            checkOutput($sformatf("vec%0d store", i), bus.ex_store_data, tbl[i].exp_store);
            checkOutput($sformatf("vec%0d ex_rd", i), bus.ex_rd, tbl[i].exp_rd);
         end
      end

      // ---------------- load-use ----------------
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 4; v.rd = 4; v.mr = 1; v.rw = 1;
      applyStimulus(v);
      step();
      v = blank(); v.valid = 1; v.rs = 4; v.rt = 2; v.rd = 5; v.rs_data = 32'h40; v.rt_data = 32'h2; v.rw = 1;
      applyStimulus(v);
      #1;
      checkOutput("loaduse stall_id", bus.stall_id, 1);
      step();
      checkOutput("loaduse bubble ex_valid", bus.ex_valid, 0);
      checkOutput("loaduse bubble mem_read", bus.ex_mem_read, 0);
      checkOutput("loaduse stall released", bus.stall_id, 0);
      checkOutput("loaduse stall_count", bus.stall_count, 1);
      step();
      checkOutput("loaduse issue ex_valid", bus.ex_valid, 1);
      checkOutput("loaduse issue ex_rd", bus.ex_rd, 5);
      checkOutput("loaduse issue alu_a", bus.alu_a, 32'h40);
      checkOutput("loaduse count hold", bus.stall_count, 1);

      // load to $0 never stalls
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 0; v.rd = 0; v.mr = 1;
      applyStimulus(v);
      step();
      v = blank(); v.valid = 1; v.rs = 0; v.rt = 0; v.rd = 5;
      applyStimulus(v);
      #1;
      checkOutput("load r0 stall_id", bus.stall_id, 0);
      step();

      // ---------------- flush plus stall ----------------
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 4; v.rd = 4; v.mr = 1; v.rw = 1;
      applyStimulus(v);
      step();
      v = blank(); v.valid = 1; v.rs = 4; v.rt = 2; v.rd = 5; v.rw = 1; v.flush = 1;
      applyStimulus(v);
      #1;
      checkOutput("flushstall stall_id", bus.stall_id, 1);
      step();
      checkOutput("flushstall ex_valid", bus.ex_valid, 0);
      checkOutput("flushstall ex_reg_write", bus.ex_reg_write, 0);
      checkOutput("flushstall stall_count", bus.stall_count, 1);

      // ---------------- reset mid-stream ----------------
      v = blank(); v.valid = 1; v.rs = 1; v.rt = 2; v.rd = 3; v.rw = 1; v.op = 6'h22;
      applyStimulus(v);
      step();
      checkOutput("midreset pre ex_valid", bus.ex_valid, 1);
      checkOutput("midreset pre alu_op", bus.alu_op, 6'h22);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset ex_valid", bus.ex_valid, 0);
      checkOutput("midreset alu_op", bus.alu_op, OP_ADD);
      checkOutput("midreset stall_count", bus.stall_count, 0);
      applyStimulus(idle);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // ---------------- saturation on the 4-bit counter instance ----------------
      for (int i = 1; i <= 20; i++) begin
         sbus.id_valid = 1; sbus.id_rs = 0; sbus.id_rt = 0; sbus.id_rd = 4; sbus.id_mem_read = 1;
         step();
         sbus.id_rs = 4; sbus.id_rd = 5; sbus.id_mem_read = 0;
         step();
         if (i == 1 || i == 14 || i == 15 || i == 20) begin
            checkOutput($sformatf("sat count after %0d", i), sbus.stall_count, (i < 15) ? i : 15);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
